// File: rtl/sdcram_arbiter_if.sv
// Requester and sdcram command/response signal bundle for sdcram_arbiter.
// slave: arbiter side; master: requesters plus sdcram model side.
interface sdcram_arbiter_if #(
    parameter int ADDR_W = 41
);
    logic              r0_req,   r1_req;
    logic [ADDR_W-1:0] r0_addr,  r1_addr;
    logic              r0_ren,   r1_ren;
    logic [3:0]        r0_wen,   r1_wen;
    logic [31:0]       r0_wdata, r1_wdata;
    logic              r0_done,  r1_done;
    logic [31:0]       r0_rdata, r1_rdata;
    logic [ADDR_W-1:0] o_sdcram_addr;
    logic              o_sdcram_ren;
    logic [3:0]        o_sdcram_wen;
    logic [31:0]       o_sdcram_wdata;
    logic [31:0]       i_sdcram_rdata;
    logic              i_sdcram_busy;
    logic              owner;

    modport slave (
        input  r0_req, r1_req, r0_addr, r1_addr, r0_ren, r1_ren,
        input  r0_wen, r1_wen, r0_wdata, r1_wdata,
        output r0_done, r1_done, r0_rdata, r1_rdata,
        output o_sdcram_addr, o_sdcram_ren, o_sdcram_wen, o_sdcram_wdata,
        input  i_sdcram_rdata, i_sdcram_busy,
        output owner
    );

    modport master (
        output r0_req, r1_req, r0_addr, r1_addr, r0_ren, r1_ren,
        output r0_wen, r1_wen, r0_wdata, r1_wdata,
        input  r0_done, r1_done, r0_rdata, r1_rdata,
        input  o_sdcram_addr, o_sdcram_ren, o_sdcram_wen, o_sdcram_wdata,
        output i_sdcram_rdata, i_sdcram_busy,
        input  owner
    );
endinterface

// File: rtl/sdcram_arbiter.sv
// Two-requester arbiter in front of a single sdcram command port.
// Define SDCRAM_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module sdcram_arbiter #(
    parameter int ADDR_W     = 41,
    parameter int GAP_CYCLES = 1
) (
    input logic             CLK,
    input logic             RST,
    sdcram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ren;
    logic [3:0]        cmd_wen;
    logic [31:0]       cmd_wdata;
    logic              cmd_idx;
    logic [3:0]        gap_cnt;
    logic [31:0]       rdata0, rdata1;
    logic              win, grant, win_ren;
    logic [3:0]        win_wen;

`ifdef SDCRAM_ARB_RR_EN
    // prio names the requester preferred on the next simultaneous request
    logic prio;

    always_comb begin
        if (bus.r0_req && bus.r1_req) win = prio;
        else                          win = ~bus.r0_req;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        prio <= 1'b0;
        else if (grant) prio <= ~win;
    end
`else
    always_comb win = ~bus.r0_req;
`endif

    always_comb begin
        grant   = (state == IDLE) && (bus.r0_req || bus.r1_req) && !bus.i_sdcram_busy;
        win_ren = win ? bus.r1_ren : bus.r0_ren;
        win_wen = win ? bus.r1_wen : bus.r0_wen;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.o_sdcram_ren   = 1'b0;
        bus.o_sdcram_wen   = '0;
        bus.o_sdcram_addr  = cmd_addr;
        bus.o_sdcram_wdata = cmd_wdata;
        bus.r0_done        = 1'b0;
        bus.r1_done        = 1'b0;
        bus.r0_rdata       = rdata0;
        bus.r1_rdata       = rdata1;
        bus.owner          = cmd_idx;
        case (state)
            IDLE: begin
                // an empty command skips the sdcram entirely
                if (grant) state_nxt = (win_ren || (win_wen != '0)) ? ISSUE : DONE;
            end
            ISSUE: begin
                bus.o_sdcram_ren = cmd_ren;
                bus.o_sdcram_wen = cmd_wen;
                state_nxt        = GAP;
            end
            GAP: begin
                if (gap_cnt == 4'(GAP_CYCLES - 1)) state_nxt = WAIT;
            end
            WAIT: begin
                if (!bus.i_sdcram_busy) state_nxt = DONE;
            end
            DONE: begin
                bus.r0_done = ~cmd_idx;
                bus.r1_done = cmd_idx;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd_addr  <= '0;
            cmd_ren   <= 1'b0;
            cmd_wen   <= '0;
            cmd_wdata <= '0;
            cmd_idx   <= 1'b0;
            gap_cnt   <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            if (grant) begin
                cmd_addr  <= win ? bus.r1_addr  : bus.r0_addr;
                cmd_ren   <= win_ren;
                cmd_wen   <= win_wen;
                cmd_wdata <= win ? bus.r1_wdata : bus.r0_wdata;
                cmd_idx   <= win;
            end
            if (state == ISSUE)    gap_cnt <= '0;
            else if (state == GAP) gap_cnt <= gap_cnt + 4'd1;
            if ((state == WAIT) && !bus.i_sdcram_busy && cmd_ren) begin
                if (cmd_idx) rdata1 <= bus.i_sdcram_rdata;
                else         rdata0 <= bus.i_sdcram_rdata;
            end
        end
    end

endmodule

// File: doc/sdcram_arbiter.md
SDCRAM_ARBITER -- requirements
Module: sdcram_arbiter

Interface
REQ-001 Parameter ADDR_W, 41, requester and sdcram address width.
REQ-002 Parameter GAP_CYCLES, 1, cycles between command pulse and first busy sample, range 1..15.
REQ-003 CLK  input  1  single clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 r0_req, r1_req  input  1 each  request; held high with stable command until matching done.
REQ-006 r0_addr, r1_addr  input  ADDR_W each  byte address.
REQ-007 r0_ren, r1_ren  input  1 each  read command; mutually exclusive with nonzero wen.
REQ-008 r0_wen, r1_wen  input  4 each  byte write enables.
REQ-009 r0_wdata, r1_wdata  input  32 each  write data.
REQ-010 r0_done, r1_done  output  1 each  one-cycle completion pulse.
REQ-011 r0_rdata, r1_rdata  output  32 each  read data, valid from done pulse until next completion for that requester.
REQ-012 o_sdcram_addr  output  ADDR_W; o_sdcram_ren  output  1; o_sdcram_wen  output  4; o_sdcram_wdata  output  32  sdcram command port.
REQ-013 i_sdcram_rdata  input  32; i_sdcram_busy  input  1  sdcram response.
REQ-014 owner  output  1  index of last granted requester (debug).

Function
REQ-015 FSM states IDLE, ISSUE, GAP, WAIT, DONE; encoded in 3 bits.
REQ-016 IDLE: when i_sdcram_busy low and any req high, latch winner's addr/ren/wen/wdata and index, go ISSUE; else stay.
REQ-017 Requester with req high but ren low and wen zero is completed directly: IDLE -> DONE, no sdcram command.
REQ-018 ISSUE: drive latched ren/wen for exactly one cycle, go GAP; ren and wen outputs are zero in every other state.
REQ-019 o_sdcram_addr and o_sdcram_wdata are driven from latched values in all states, zero after reset.
REQ-020 GAP: count GAP_CYCLES cycles, then go WAIT.
REQ-021 WAIT: when i_sdcram_busy low, capture i_sdcram_rdata into winner's rdata register if read, go DONE.
REQ-022 DONE: pulse winner's done for one cycle, return IDLE; next grant earliest the following cycle.
REQ-023 Latency, uncontended with busy low: done asserts GAP_CYCLES+3 cycles after req rises.
REQ-024 Non-winner rdata registers are never modified by another requester's transaction.
REQ-025 Requester dropping req mid-transaction is not an error; transaction completes and done still pulses.
REQ-026 i_sdcram_busy high in IDLE blocks all grants; no timeout.
REQ-027 Arbitration decision uses only values sampled in IDLE; req changes in other states have no effect until IDLE.

Reset
REQ-028 RST asserted: state IDLE, all outputs zero, latched command zero, owner 0, priority pointer to requester 0, within the same cycle (asynchronous).
REQ-029 RST asserted mid-transaction aborts it; no done pulse; sdcram command outputs drop to zero immediately.
REQ-030 RST deassertion takes effect at the next posedge CLK; first grant possible on that edge.

Configuration
REQ-031 Macro SDCRAM_ARB_RR_EN defined: round-robin; on simultaneous requests the requester not equal to owner wins; owner updates on each grant.
REQ-032 Macro SDCRAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins simultaneous requests; owner still reports last grant.

Verification
REQ-033 Write: r0 req, addr 0x10, wen 0001, wdata 0xA5, busy low -> one-cycle wen 0001 at addr 0x10, r0_done at cycle 4 (GAP_CYCLES 1).
REQ-034 Read: r1 read addr 0x20, busy high 10 cycles after ISSUE, rdata 0xDEADBEEF -> r1_rdata 0xDEADBEEF with r1_done after busy falls; r0_rdata unchanged.
REQ-035 Contention, RR_EN defined: both req held for 4 transactions -> grants r0,r1,r0,r1; undefined -> r0,r0,r0,r0 until r0 drops.
REQ-036 busy held high before requests -> no command issued, no done; release busy -> grant next cycle.
REQ-037 RST pulse in WAIT -> outputs zero asynchronously, no done; after release, held req reissued from IDLE.
REQ-038 Empty command (ren 0, wen 0000) -> done pulse, sdcram ren/wen stay zero.
